// File: rtl/universal_shift_reg_if.sv
// Control, data and status bundle for universal_shift_reg.
// The master drives mode/serial/parallel inputs; the slave returns register state.
interface universal_shift_reg_if #(
  parameter int unsigned NBITS = 4
) ();
  localparam int unsigned CW = $clog2(NBITS);

  logic             enable;
  logic [2:0]       mode;
  logic             ser_in_r;
  logic             ser_in_l;
  logic [NBITS-1:0] par_in;
  logic [NBITS-1:0] q;
  logic             ser_out_r;
  logic             ser_out_l;
  logic [CW-1:0]    shift_cnt;
  logic             word_ready;

  modport master (
    output enable, mode, ser_in_r, ser_in_l, par_in,
    input  q, ser_out_r, ser_out_l, shift_cnt, word_ready
  );

  modport slave (
    input  enable, mode, ser_in_r, ser_in_l, par_in,
    output q, ser_out_r, ser_out_l, shift_cnt, word_ready
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Run-time selectable shift register: hold, shift L/R, load, rotate, clear.
// Counts serial shifts and pulses word_ready when a full NBITS-bit word has been shifted.
module universal_shift_reg #(
  parameter int unsigned NBITS = 4
) (
  input logic                  clk_2,
  input logic                  reset,
  universal_shift_reg_if.slave bus
);
  localparam int unsigned CW = $clog2(NBITS);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;

  logic [NBITS-1:0] q_d, q_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic             wr_d, wr_q;
  logic             shift_c;

  // Next-state: data path, shift counter and word-complete pulse
  always_comb begin
    q_d     = q_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    shift_c = 1'b0;
    if (bus.enable) begin
      case (bus.mode)
        MODE_HOLD: q_d = q_q;
        MODE_SHR: begin
          q_d     = {bus.ser_in_r, q_q[NBITS-1:1]};
          shift_c = 1'b1;
        end
        MODE_SHL: begin
          q_d     = {q_q[NBITS-2:0], bus.ser_in_l};
          shift_c = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = bus.par_in;
          cnt_d = '0;
        end
        MODE_ROR: q_d = {q_q[0], q_q[NBITS-1:1]};
        MODE_ROL: q_d = {q_q[NBITS-2:0], q_q[NBITS-1]};
        MODE_CLR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        default: q_d = q_q;
      endcase
      // Either direction counts toward the same word
      if (shift_c) begin
        if (cnt_q == CW'(NBITS - 1)) begin
          cnt_d = '0;
          wr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      q_q   <= '0;
      cnt_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
    end
  end

  assign bus.q          = q_q;
  assign bus.ser_out_r  = q_q[0];
  assign bus.ser_out_l  = q_q[NBITS-1];
  assign bus.shift_cnt  = cnt_q;
  assign bus.word_ready = wr_q;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed plan steps plus random traffic, checked against an arithmetic model of
// the register value, the shift count and the word-complete pulse.
module tb_universal_shift_reg;
  localparam int unsigned N = 4;

  logic clk_2 = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  int m_q   = 0;
  int m_cnt = 0;
  int m_wr  = 0;

  universal_shift_reg_if #(.NBITS(N)) bus ();

  universal_shift_reg #(.NBITS(N)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: register value as an integer modulo 2**N, count modulo N
  task automatic model(input bit rst, input bit en, input int md, input int sr,
                       input int sl, input int pin);
    bit counted;
    counted = 1'b0;
    m_wr = 0;
    if (rst) begin
      m_q = 0;
      m_cnt = 0;
    end else if (en) begin
      case (md)
        1: begin m_q = (m_q / 2) + sr * (1 << (N - 1)); counted = 1'b1; end
        2: begin m_q = (m_q * 2 + sl) % (1 << N); counted = 1'b1; end
        3: begin m_q = pin; m_cnt = 0; end
        4: m_q = (m_q / 2) + (m_q % 2) * (1 << (N - 1));
        5: m_q = (m_q * 2) % (1 << N) + m_q / (1 << (N - 1));
        6: begin m_q = 0; m_cnt = 0; end
        default: ;
      endcase
      if (counted) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == N) begin
          m_cnt = 0;
          m_wr = 1;
        end
      end
    end
  endtask

  // Drive one cycle, advance the model, compare every output after the edge
  task automatic cyc(input bit rst, input bit en, input int md, input int sr,
                     input int sl, input int pin);
    reset        = rst;
    bus.enable   = en;
    bus.mode     = 3'(md);
    bus.ser_in_r = sr[0];
    bus.ser_in_l = sl[0];
    bus.par_in   = N'(pin);
    model(rst, en, md, sr, sl, pin);
    @(posedge clk_2);
    #1;
    chk("q", int'(bus.q), m_q);
    chk("shift_cnt", int'(bus.shift_cnt), m_cnt);
    chk("word_ready", int'(bus.word_ready), m_wr);
    chk("ser_out_r", int'(bus.ser_out_r), m_q % 2);
    chk("ser_out_l", int'(bus.ser_out_l), m_q / (1 << (N - 1)));
  endtask

  task automatic lit(input string tag, input int q_exp, input int cnt_exp, input int wr_exp);
    chk({tag, ".q"}, int'(bus.q), q_exp);
    chk({tag, ".cnt"}, int'(bus.shift_cnt), cnt_exp);
    chk({tag, ".wr"}, int'(bus.word_ready), wr_exp);
  endtask

  initial begin
    int wr_seen;
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.mode     = 3'b000;
    bus.ser_in_r = 1'b0;
    bus.ser_in_l = 1'b0;
    bus.par_in   = '0;

    // Reset overrides a pending load
    cyc(1, 1, 3, 0, 0, 'b1111);
    lit("reset", 'b0000, 0, 0);

    // Parallel load
    cyc(0, 1, 3, 0, 0, 'b1010);
    lit("load", 'b1010, 0, 0);
    chk("load.ser_out_r", int'(bus.ser_out_r), 0);
    chk("load.ser_out_l", int'(bus.ser_out_l), 1);

    // Serial word shifted in from the right
    cyc(0, 1, 6, 0, 0, 0);
    lit("clear", 'b0000, 0, 0);
    cyc(0, 1, 1, 1, 0, 0); lit("shr1", 'b1000, 1, 0);
    cyc(0, 1, 1, 0, 0, 0); lit("shr2", 'b0100, 2, 0);
    cyc(0, 1, 1, 1, 0, 0); lit("shr3", 'b1010, 3, 0);
    cyc(0, 1, 1, 1, 0, 0); lit("shr4", 'b1101, 0, 1);

    // Rotate left, then hold with enable low
    cyc(0, 1, 3, 0, 0, 'b1001);
    cyc(0, 1, 5, 0, 0, 0); lit("rol1", 'b0011, 0, 0);
    cyc(0, 1, 5, 0, 0, 0); lit("rol2", 'b0110, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 1, 0);
      lit("en_low", 'b0110, 0, 0);
    end

    // Mixed directions complete one word
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0); lit("mix_r", 'b0001, 2, 0);
    cyc(0, 1, 2, 0, 1, 0); lit("mix_l1", 'b0011, 3, 0);
    cyc(0, 1, 2, 0, 1, 0); lit("mix_l2", 'b0111, 0, 1);
    cyc(0, 1, 0, 0, 0, 0); lit("mix_after", 'b0111, 0, 0);

    // Reset mid-word drops the partial count
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 0, 0);
    lit("pre_rst", 'b1110, 3, 0);
    cyc(1, 1, 1, 1, 0, 0);
    lit("mid_rst", 'b0000, 0, 0);
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 1, 0, 0);
      if (i < 3) wr_seen += int'(bus.word_ready);
    end
    chk("post_rst.early_wr", wr_seen, 0);
    lit("post_rst", 'b1111, 0, 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 40) == 0, ($urandom % 4) != 0, int'($urandom % 8),
          int'($urandom % 2), int'($urandom % 2), int'($urandom % (1 << N)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised universal shift register, successor to the fixed 4-bit parallel-load and serial-in shift pair. It provides hold, left/right shift with serial in/out, parallel load, rotate and clear, all selectable at run time. A shift counter flags each completed serial word. It sits between switch/serial inputs and LED/LCD display logic in the top-level.

Parameters:
NBITS, 4, register width in bits; legal range NBITS >= 2.
CW, $clog2(NBITS) (derived localparam, not overridable), shift counter width.

Ports:
clk_2  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  1 = execute mode this cycle; 0 = hold all state.
mode  input  3  operation select (encoding below).
ser_in_r  input  1  serial input, enters at MSB on shift right.
ser_in_l  input  1  serial input, enters at LSB on shift left.
par_in  input  NBITS  parallel load data.
q  output  NBITS  register contents.
ser_out_r  output  1  q[0], combinational from register.
ser_out_l  output  1  q[NBITS-1], combinational from register.
shift_cnt  output  CW  shifts completed in the current word.
word_ready  output  1  registered one-cycle pulse: NBITS shifts completed.

Behaviour:
- Reset (sync, highest priority): q=0, shift_cnt=0, word_ready=0 on the next rising edge. Reset overrides enable and mode.
- Reset mid-word discards the partial word and its count.
- enable=0: q and shift_cnt hold; word_ready=0.
- Mode encoding when enable=1, with q updating at the same edge (latency 1 cycle):
  000 hold: q unchanged.
  001 shift right: q <= {ser_in_r, q[NBITS-1:1]}.
  010 shift left: q <= {q[NBITS-2:0], ser_in_l}.
  011 parallel load: q <= par_in.
  100 rotate right: q <= {q[0], q[NBITS-1:1]}.
  101 rotate left: q <= {q[NBITS-2:0], q[NBITS-1]}.
  110 clear: q <= 0.
  111 reserved: behaves as hold.
- shift_cnt:
  - Increments only on modes 001 and 010 with enable=1.
  - Shift direction may change mid-word; both directions count toward the same word.
  - Modes 011 and 110 set shift_cnt to 0.
  - Modes 000, 100, 101 and 111 leave shift_cnt unchanged.
  - When shift_cnt==NBITS-1 and a counted shift occurs, shift_cnt wraps to 0.
- word_ready:
  - Set to 1 on the edge where the wrap occurs. It is therefore high in the same cycle q shows the completed word.
  - Cleared on the next edge unless another wrap occurs at that edge. Back-to-back words are impossible for NBITS >= 2.
  - 0 at every other edge, including load, clear and enable=0.
- Serial outputs always reflect the current q; there is no extra register stage.
- No X-propagation: all state is defined from the first reset onward.

Test Plan:
1. Reset: NBITS=4, assert reset for 1 cycle with mode=011, par_in=1111 -> q=0000, shift_cnt=0, word_ready=0 after the edge.
2. Parallel load: enable=1, mode=011, par_in=1010 -> q=1010, shift_cnt=0, word_ready=0 next cycle; ser_out_r=0, ser_out_l=1.
3. Shift right serial word: from q=0000, mode=001, ser_in_r=1,0,1,1 on successive edges.
   - q sequence 1000, 0100, 1010, 1101.
   - shift_cnt 1,2,3,0.
   - word_ready=1 only in the cycle q=1101.
4. Rotate and enable: load 1001, then mode=101 twice -> q=0011, then 0110, with shift_cnt unchanged. Then enable=0, mode=001 for 3 cycles -> q stays 0110.
5. Mixed direction: after 2 right shifts (shift_cnt=2), do 2 left shifts with ser_in_l=1,1 -> shift_cnt wraps to 0 and word_ready pulses once; the low 2 bits of q are 11.
6. Reset mid-word: after 3 shifts (shift_cnt=3), assert reset together with mode=001 -> q=0000, shift_cnt=0, and no word_ready pulse. The next word needs a full 4 shifts to pulse.
